// File: rtl/hash160_pkg.sv
// Shared types and constants for the HASH160 job scheduler.
package hash160_pkg;

    // Scheduler phases: wait for a job, SHA-256 pass, RIPEMD-160 pass, stream result.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHA_RUN,
        ST_RMD_RUN,
        ST_OUTPUT
    } state_e;

    // RIPEMD-160 padding of a 256-bit message: length field and the single pad bit.
    localparam logic [63:0] RMD_LEN_BITS = 64'd256;
    localparam logic        RMD_PAD_BIT  = 1'b1;

    // Ten 16-bit words cover the full 160-bit digest.
    localparam int OUT_WORDS_DEF = 10;

    // Build the single padded block fed to the RIPEMD-160 core from a SHA-256 digest.
    function automatic logic [511:0] rmd_pad(input logic [255:0] digest);
        return {RMD_LEN_BITS, 191'b0, RMD_PAD_BIT, digest};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last requester served.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    // 1 means requester 1 was served last, so requester 0 wins a tie after reset.
    logic last_q;

    // Grant the sole requester, or on a tie the one not served last.
    always_comb begin
        // NOTE: default first so every path assigns gnt_o and no latch is inferred.
        gnt_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    // Move the pointer to whoever was granted this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (|gnt_o) begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            last_q <= gnt_o[1];
        end
    end

endmodule

// File: rtl/hash160_sched.sv
// HASH160 job scheduler: arbitrates two requesters, sequences an external SHA-256
// core then an external RIPEMD-160 core, and streams the 160-bit result as 16-bit words.
module hash160_sched
    import hash160_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1023,
    parameter int OUT_WORDS   = OUT_WORDS_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    input  logic [511:0] req_block0,
    input  logic [511:0] req_block1,
    output logic [1:0]   req_ready,
    output logic         sha_start,
    output logic [511:0] sha_block,
    input  logic         sha_done,
    input  logic [255:0] sha_digest,
    output logic         rmd_start,
    output logic [511:0] rmd_block,
    input  logic         rmd_done,
    input  logic [159:0] rmd_digest,
    output logic         o_valid,
    output logic         o_id,
    output logic [15:0]  o_answer,
    output logic         o_err,
    output logic         busy
);

    localparam int            CW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC);
    localparam int            WW      = $clog2(OUT_WORDS + 1);
    localparam logic [WW-1:0] OW_LAST = WW'(OUT_WORDS - 1);

    state_e         state_q;
    logic [511:0]   job_q;
    logic           id_q;
    logic           sha_start_q;
    logic           rmd_start_q;
    logic [511:0]   rmd_blk_q;
    logic [159:0]   dig_q;
    logic [CW-1:0]  cnt_q;
    logic [WW-1:0]  word_q;
    logic           o_valid_q;
    logic           o_err_q;

    logic [1:0]     gnt;
    logic           xfer;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q == ST_IDLE),
        .req_i (req_valid),
        .gnt_o (gnt)
    );

    // Grants only ever go to asserted requests, so any grant is a transfer.
    assign xfer = |gnt;

    // Phase sequencing, core launch pulses, per-phase timeout and result shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            job_q       <= '0;
            id_q        <= 1'b0;
            sha_start_q <= 1'b0;
            rmd_start_q <= 1'b0;
            rmd_blk_q   <= '0;
            dig_q       <= '0;
            cnt_q       <= '0;
            word_q      <= '0;
            o_valid_q   <= 1'b0;
            o_err_q     <= 1'b0;
        end else begin
            sha_start_q <= 1'b0;
            rmd_start_q <= 1'b0;
            o_err_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        job_q       <= gnt[1] ? req_block1 : req_block0;
                        id_q        <= gnt[1];
                        sha_start_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= ST_SHA_RUN;
                    end
                end
                // cnt_q == 0 marks the launch cycle, where a done pulse cannot be genuine.
                ST_SHA_RUN: begin
                    if (cnt_q != '0 && sha_done) begin
                        rmd_blk_q   <= rmd_pad(sha_digest);
                        rmd_start_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= ST_RMD_RUN;
                    end else if (cnt_q == TO_LAST) begin
                        o_err_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RMD_RUN: begin
                    if (cnt_q != '0 && rmd_done) begin
                        dig_q     <= rmd_digest;
                        word_q    <= '0;
                        o_valid_q <= 1'b1;
                        state_q   <= ST_OUTPUT;
                    end else if (cnt_q == TO_LAST) begin
                        o_err_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    dig_q <= {dig_q[143:0], 16'h0000};
                    if (word_q == OW_LAST) begin
                        o_valid_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        word_q <= word_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = gnt;
    assign sha_start = sha_start_q;
    assign sha_block = job_q;
    assign rmd_start = rmd_start_q;
    assign rmd_block = rmd_blk_q;
    assign o_valid   = o_valid_q;
    assign o_id      = o_valid_q & id_q;
    assign o_answer  = o_valid_q ? dig_q[159:144] : 16'h0000;
    assign o_err     = o_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hash160_sched.sv
// Directed bench for hash160_sched: instance a uses the default timeout for the
// long-latency job, instance b uses TIMEOUT_CYC=16 for everything else.
module tb_hash160_sched;

    logic         clk;
    logic         rst;
    logic [1:0]   req_valid;
    logic [511:0] req_block0, req_block1;
    logic         sha_done, rmd_done;
    logic [255:0] sha_digest;
    logic [159:0] rmd_digest;

    logic [1:0]   req_ready_a, req_ready_b;
    logic         sha_start_a, sha_start_b;
    logic [511:0] sha_block_a, sha_block_b;
    logic         rmd_start_a, rmd_start_b;
    logic [511:0] rmd_block_a, rmd_block_b;
    logic         o_valid_a, o_valid_b;
    logic         o_id_a, o_id_b;
    logic [15:0]  o_answer_a, o_answer_b;
    logic         o_err_a, o_err_b;
    logic         busy_a, busy_b;

    int n_vec = 0;
    int n_err = 0;

    hash160_sched u_a (
        .clk(clk), .rst(rst), .req_valid(req_valid),
        .req_block0(req_block0), .req_block1(req_block1), .req_ready(req_ready_a),
        .sha_start(sha_start_a), .sha_block(sha_block_a),
        .sha_done(sha_done), .sha_digest(sha_digest),
        .rmd_start(rmd_start_a), .rmd_block(rmd_block_a),
        .rmd_done(rmd_done), .rmd_digest(rmd_digest),
        .o_valid(o_valid_a), .o_id(o_id_a), .o_answer(o_answer_a),
        .o_err(o_err_a), .busy(busy_a)
    );

    hash160_sched #(.TIMEOUT_CYC(16)) u_b (
        .clk(clk), .rst(rst), .req_valid(req_valid),
        .req_block0(req_block0), .req_block1(req_block1), .req_ready(req_ready_b),
        .sha_start(sha_start_b), .sha_block(sha_block_b),
        .sha_done(sha_done), .sha_digest(sha_digest),
        .rmd_start(rmd_start_b), .rmd_block(rmd_block_b),
        .rmd_done(rmd_done), .rmd_digest(rmd_digest),
        .o_valid(o_valid_b), .o_id(o_id_b), .o_answer(o_answer_b),
        .o_err(o_err_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Registers settle shortly after the edge; inputs are driven at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starting in the launch cycle of SHA_RUN on instance b: finish the job quickly
    // and check every streamed word against the digest handed to the RIPEMD core.
    task automatic serve(input logic exp_id, input logic [159:0] dig);
        tick();
        sha_digest = {dig, 96'h0};
        sha_done   = 1'b1;
        tick();
        sha_done = 1'b0;
        check("serve_rmd_start", rmd_start_b, 1'b1);
        check("serve_no_grant_busy", req_ready_b, 2'b00);
        tick();
        rmd_digest = dig;
        rmd_done   = 1'b1;
        tick();
        rmd_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("serve_valid_%0d", i), o_valid_b, 1'b1);
            check($sformatf("serve_id_%0d", i), o_id_b, exp_id);
            check($sformatf("serve_word_%0d", i), o_answer_b, dig[159-16*i -: 16]);
            tick();
        end
        check("serve_end_valid", o_valid_b, 1'b0);
        check("serve_end_busy", busy_b, 1'b0);
    endtask

    localparam logic [159:0] D_A = 160'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_a5a5_5a5a;
    localparam logic [511:0] B0  = {16{32'hb0b0_0000}} ^ 512'h1;
    localparam logic [511:0] B1  = {16{32'hb1b1_1111}};
    localparam logic [255:0] SD  = {8{32'h5d5d_c0de}};

    initial begin
        logic [15:0]  exp_a [10];
        logic [511:0] rb;
        exp_a = '{16'h0123, 16'h4567, 16'h89ab, 16'hcdef, 16'hfedc,
                  16'hba98, 16'h7654, 16'h3210, 16'ha5a5, 16'h5a5a};

        rst = 1'b1; req_valid = 2'b00; req_block0 = B0; req_block1 = B1;
        sha_done = 1'b0; rmd_done = 1'b0; sha_digest = '0; rmd_digest = '0;
        tick(); tick();

        // Reset state
        check("rst_busy", busy_a, 1'b0);
        check("rst_valid", o_valid_a, 1'b0);
        check("rst_sha_start", sha_start_a, 1'b0);
        check("rst_sha_block", sha_block_a, 512'h0);
        check("rst_rmd_block", rmd_block_a, 512'h0);
        check("rst_err", o_err_a, 1'b0);
        rst = 1'b0;
        tick();

        // Single long job on requester 0 (instance a)
        req_valid = 2'b01;
        #1;
        check("a_ready_single", req_ready_a, 2'b01);
        tick();
        check("a_sha_start", sha_start_a, 1'b1);
        check("a_sha_block", sha_block_a, B0);
        check("a_busy", busy_a, 1'b1);
        check("a_ready_busy", req_ready_a, 2'b00);
        req_valid = 2'b00;
        tick();
        check("a_sha_start_once", sha_start_a, 1'b0);
        repeat (63) tick();
        check("a_still_sha", rmd_start_a, 1'b0);
        sha_digest = SD; sha_done = 1'b1;
        tick();
        sha_done = 1'b0;
        rb = rmd_block_a;
        check("a_rmd_start", rmd_start_a, 1'b1);
        check("a_rmd_len", rb[511:448], 64'd256);
        check("a_rmd_zero", rb[447:257], 191'b0);
        check("a_rmd_pad", rb[256], 1'b1);
        check("a_rmd_digest", rb[255:0], SD);
        tick();
        check("a_rmd_start_once", rmd_start_a, 1'b0);
        repeat (79) tick();
        check("a_no_valid_yet", o_valid_a, 1'b0);
        rmd_digest = D_A; rmd_done = 1'b1;
        tick();
        rmd_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("a_valid_%0d", i), o_valid_a, 1'b1);
            check($sformatf("a_id_%0d", i), o_id_a, 1'b0);
            check($sformatf("a_word_%0d", i), o_answer_a, exp_a[i]);
            tick();
        end
        check("a_end_valid", o_valid_a, 1'b0);
        check("a_end_answer", o_answer_a, 16'h0);
        check("a_end_busy", busy_a, 1'b0);

        // Spurious done pulses in IDLE and in launch cycles (instance b)
        rst = 1'b1; tick(); rst = 1'b0; tick();
        sha_done = 1'b1; rmd_done = 1'b1;
        tick();
        sha_done = 1'b0; rmd_done = 1'b0;
        check("sp_idle_busy", busy_b, 1'b0);
        check("sp_idle_valid", o_valid_b, 1'b0);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        check("sp_sha_start", sha_start_b, 1'b1);
        sha_done = 1'b1;
        tick();
        sha_done = 1'b0;
        check("sp_sha_launch_ignored", rmd_start_b, 1'b0);
        check("sp_sha_busy", busy_b, 1'b1);
        sha_done = 1'b1;
        tick();
        sha_done = 1'b0;
        check("sp_rmd_start", rmd_start_b, 1'b1);
        rmd_done = 1'b1;
        tick();
        rmd_done = 1'b0;
        check("sp_rmd_launch_ignored", o_valid_b, 1'b0);
        rmd_done = 1'b1;
        tick();
        rmd_done = 1'b0;
        check("sp_output", o_valid_b, 1'b1);
        repeat (10) tick();
        check("sp_done_idle", busy_b, 1'b0);

        // Both requesters valid continuously: grants alternate 0,1,0,1
        rst = 1'b1; tick(); rst = 1'b0; tick();
        req_valid = 2'b11;
        #1;
        check("rr_grant0", req_ready_b, 2'b01);
        tick();
        check("rr_block0", sha_block_b, B0);
        serve(1'b0, 160'h1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa);
        check("rr_grant1", req_ready_b, 2'b10);
        tick();
        check("rr_block1", sha_block_b, B1);
        serve(1'b1, 160'hbbbb_cccc_dddd_eeee_ffff_0000_1234_5678_9abc_def0);
        check("rr_grant2", req_ready_b, 2'b01);
        tick();
        serve(1'b0, 160'h0f0f_f0f0_3c3c_c3c3_6969_9696_0000_ffff_8001_7ffe);
        check("rr_grant3", req_ready_b, 2'b10);
        tick();
        req_valid = 2'b00;
        serve(1'b1, 160'hdead_beef_cafe_babe_f00d_face_1357_9bdf_2468_ace0);

        // SHA timeout with TIMEOUT_CYC=16
        rst = 1'b1; tick(); rst = 1'b0; tick();
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        for (int k = 0; k < 17; k++) begin
            check($sformatf("to_no_err_%0d", k), o_err_b, 1'b0);
            check($sformatf("to_busy_%0d", k), busy_b, 1'b1);
            tick();
        end
        check("to_err_pulse", o_err_b, 1'b1);
        check("to_idle", busy_b, 1'b0);
        check("to_no_valid", o_valid_b, 1'b0);
        tick();
        check("to_err_once", o_err_b, 1'b0);
        req_valid = 2'b11;
        #1;
        check("to_pointer_kept", req_ready_b, 2'b10);
        tick();
        req_valid = 2'b00;
        check("to_next_block", sha_block_b, B1);
        serve(1'b1, 160'h0123_4567_89ab_cdef_0123_4567_89ab_cdef_0123_4567);

        // rmd_done coincident with the timeout cycle: done wins
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        sha_done = 1'b1;
        tick();
        sha_done = 1'b0;
        check("co_rmd_start", rmd_start_b, 1'b1);
        repeat (16) tick();
        check("co_still_busy", busy_b, 1'b1);
        rmd_digest = D_A; rmd_done = 1'b1;
        tick();
        rmd_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("co_valid_%0d", i), o_valid_b, 1'b1);
            check($sformatf("co_no_err_%0d", i), o_err_b, 1'b0);
            check($sformatf("co_word_%0d", i), o_answer_b, exp_a[i]);
            tick();
        end
        check("co_end_err", o_err_b, 1'b0);

        // Reset during output word 4
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        tick();
        sha_done = 1'b1;
        tick();
        sha_done = 1'b0;
        tick();
        rmd_digest = D_A; rmd_done = 1'b1;
        tick();
        rmd_done = 1'b0;
        repeat (4) tick();
        check("rs_word4_valid", o_valid_b, 1'b1);
        check("rs_word4_value", o_answer_b, 16'hfedc);
        rst = 1'b1;
        #1;
        check("rs_valid_drop", o_valid_b, 1'b0);
        check("rs_busy_drop", busy_b, 1'b0);
        check("rs_answer_zero", o_answer_b, 16'h0);
        tick();
        rst = 1'b0;
        tick();
        check("rs_no_err", o_err_b, 1'b0);
        sha_done = 1'b1; rmd_done = 1'b1;
        tick();
        sha_done = 1'b0; rmd_done = 1'b0;
        check("rs_late_done_ignored", busy_b, 1'b0);
        check("rs_late_no_err", o_err_b, 1'b0);
        req_valid = 2'b11;
        #1;
        check("rs_pointer_reset", req_ready_b, 2'b01);
        tick();
        req_valid = 2'b00;
        check("rs_fresh_block", sha_block_b, B0);
        serve(1'b0, 160'h4444_3333_2222_1111_0000_ffff_eeee_dddd_cccc_bbbb);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
